// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared defaults and read-owner encoding for the memory port arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int AW_DEF         = 5;
   localparam int DW_DEF         = 20;
   localparam int STARVE_MAX_DEF = 4;
   localparam int STARVE_CW      = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PIPE = 2'd1,
      OWN_IO   = 2'd2
   } owner_t;

endpackage

`default_nettype wire

// File: rtl/arb_starve_counter.sv
// ============================================================================
// Module   : arb_starve_counter
// Purpose  : Saturating count of consecutive cycles the I/O loader lost arbitration
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic i_gnt,
   output logic o_starved
);

   localparam logic [STARVE_CW-1:0] C_MAX = STARVE_CW'(STARVE_MAX);

   logic [STARVE_CW-1:0] r_cnt;

   // Any cycle the loader is served or idle breaks the losing streak.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_req && !i_gnt) begin
         if (r_cnt < C_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign o_starved = (r_cnt >= C_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the memory data port between the pipeline MEM stage and
//            the I/O loader; pipeline priority with an I/O starvation override
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          p_gnt,
   output logic [DW-1:0] p_rdata,
   output logic          p_rvalid,
   input  logic          io_req,
   input  logic          io_we,
   input  logic [AW-1:0] io_addr,
   input  logic [DW-1:0] io_wdata,
   output logic          io_gnt,
   output logic [DW-1:0] io_rdata,
   output logic          io_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_wr_en,
   input  logic [DW-1:0] q_mem,
   output logic          starved
);

   logic          w_starved;
   logic          w_io_gnt;
   logic          w_p_gnt;
   owner_t        r_owner;
   owner_t        w_owner_nxt;
   logic [DW-1:0] r_p_rdata;
   logic [DW-1:0] r_io_rdata;

   arb_starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk       (Clock),
      .rst_n     (Resetn),
      .i_req     (io_req),
      .i_gnt     (w_io_gnt),
      .o_starved (w_starved)
   );

   // Grants are gated by Resetn so nothing reaches memory while reset is held.
   assign w_io_gnt = Resetn & io_req & (~p_req | w_starved);
   assign w_p_gnt  = Resetn & p_req & ~w_io_gnt;

   always_comb begin
      mem_addr  = '0;
      mem_data  = '0;
      mem_wr_en = 1'b0;
      if (w_io_gnt) begin
         mem_addr  = io_addr;
         mem_data  = io_wdata;
         mem_wr_en = io_we;
      end else if (w_p_gnt) begin
         mem_addr  = p_addr;
         mem_data  = p_wdata;
         mem_wr_en = p_we;
      end
   end

   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (w_io_gnt && !io_we) begin
         w_owner_nxt = OWN_IO;
      end else if (w_p_gnt && !p_we) begin
         w_owner_nxt = OWN_PIPE;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_owner <= OWN_NONE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   // Read data lands in the owner's register and is held until its next read.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_p_rdata  <= '0;
         r_io_rdata <= '0;
      end else begin
         if (w_owner_nxt == OWN_PIPE) begin
            r_p_rdata <= q_mem;
         end
         if (w_owner_nxt == OWN_IO) begin
            r_io_rdata <= q_mem;
         end
      end
   end

   assign p_gnt     = w_p_gnt;
   assign io_gnt    = w_io_gnt;
   assign p_rdata   = r_p_rdata;
   assign io_rdata  = r_io_rdata;
   assign p_rvalid  = (r_owner == OWN_PIPE);
   assign io_rvalid = (r_owner == OWN_IO);
   assign starved   = w_starved;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench with a memory model and read-data scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int AW = 5;
   localparam int DW = 20;
   localparam int SM = 4;

   logic          Clock = 1'b0;
   logic          Resetn;
   logic          p_req, p_we, p_gnt, p_rvalid;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata, p_rdata;
   logic          io_req, io_we, io_gnt, io_rvalid;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_wdata, io_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wr_en;
   logic [DW-1:0] q_mem;
   logic          starved;

   logic [DW-1:0] mem [0:31] = '{28: 20'h00040, 30: 20'h00004, 31: 20'h00005, default: '0};

   logic [DW-1:0] exp_p_q[$];
   logic [DW-1:0] exp_io_q[$];
   logic [DW-1:0] exp_d;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(
      .AW (AW), .DW (DW), .STARVE_MAX (SM)
   ) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .p_req     (p_req),
      .p_we      (p_we),
      .p_addr    (p_addr),
      .p_wdata   (p_wdata),
      .p_gnt     (p_gnt),
      .p_rdata   (p_rdata),
      .p_rvalid  (p_rvalid),
      .io_req    (io_req),
      .io_we     (io_we),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_gnt    (io_gnt),
      .io_rdata  (io_rdata),
      .io_rvalid (io_rvalid),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_wr_en (mem_wr_en),
      .q_mem     (q_mem),
      .starved   (starved)
   );

   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (mem_wr_en) mem[mem_addr] <= mem_data;
   end

   assign q_mem = mem[mem_addr];

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
      io_req = 0; io_we = 0; io_addr = '0; io_wdata = '0;
   endtask

   task automatic test_reset();
      Resetn = 0;
      idle_inputs();
      p_req = 1; io_req = 1; io_we = 1;
      #3;
      checks++;
      if (p_gnt !== 1'b0 || io_gnt !== 1'b0 || mem_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_gnt: p_gnt=%b io_gnt=%b wr=%b expected 0 0 0", p_gnt, io_gnt, mem_wr_en);
      end
      checks++;
      if (p_rvalid !== 1'b0 || io_rvalid !== 1'b0 || p_rdata !== '0 || io_rdata !== '0 || starved !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs: prv=%b iorv=%b pd=%h iod=%h st=%b expected all 0",
                  p_rvalid, io_rvalid, p_rdata, io_rdata, starved);
      end
      tick();
      idle_inputs();
      Resetn = 1;
   endtask

   task automatic test_pipe_read();
      tick();
      p_req = 1; p_we = 0; p_addr = 5'h1C;
      #3;
      checks++;
      if (p_gnt !== 1'b1 || io_gnt !== 1'b0 || mem_addr !== 5'h1C || mem_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL pipe_read_gnt: p_gnt=%b io_gnt=%b addr=%h wr=%b expected 1 0 1c 0",
                  p_gnt, io_gnt, mem_addr, mem_wr_en);
      end
      exp_p_q.push_back(20'h00040);
      tick();
      p_req = 0;
      #3;
      exp_d = exp_p_q.pop_front();
      checks++;
      if (p_rvalid !== 1'b1 || p_rdata !== exp_d || io_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL pipe_read_data: rvalid=%b rdata=%h io_rvalid=%b expected 1 %h 0",
                  p_rvalid, p_rdata, io_rvalid, exp_d);
      end
      tick();
      #3;
      checks++;
      if (p_rvalid !== 1'b0 || p_rdata !== 20'h00040) begin
         failures++;
         $display("FAIL pipe_read_hold: rvalid=%b rdata=%h expected 0 00040", p_rvalid, p_rdata);
      end
   endtask

   task automatic test_io_write();
      tick();
      io_req = 1; io_we = 1; io_addr = 5'h05; io_wdata = 20'hABCDE;
      #3;
      checks++;
      if (io_gnt !== 1'b1 || p_gnt !== 1'b0 || mem_wr_en !== 1'b1 || mem_addr !== 5'h05 || mem_data !== 20'hABCDE) begin
         failures++;
         $display("FAIL io_write_port: io_gnt=%b p_gnt=%b wr=%b addr=%h data=%h expected 1 0 1 05 abcde",
                  io_gnt, p_gnt, mem_wr_en, mem_addr, mem_data);
      end
      tick();
      io_req = 0; io_we = 0;
      #3;
      checks++;
      if (mem[5] !== 20'hABCDE || io_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL io_write_commit: mem5=%h io_rvalid=%b expected abcde 0", mem[5], io_rvalid);
      end
      tick();
      io_req = 1; io_we = 0; io_addr = 5'h05;
      #3;
      exp_io_q.push_back(20'hABCDE);
      tick();
      io_req = 0;
      #3;
      exp_d = exp_io_q.pop_front();
      checks++;
      if (io_rvalid !== 1'b1 || io_rdata !== exp_d || p_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL io_readback: io_rvalid=%b io_rdata=%h p_rvalid=%b expected 1 %h 0",
                  io_rvalid, io_rdata, p_rvalid, exp_d);
      end
   endtask

   task automatic test_starvation();
      logic prev_p, prev_io, exp_io;
      prev_p = 0; prev_io = 0;
      tick();
      p_req = 1; p_we = 0; p_addr = 5'h1E;
      io_req = 1; io_we = 0; io_addr = 5'h05;
      for (int c = 0; c < 6; c++) begin
         #3;
         exp_io = (c == SM);
         checks++;
         if (io_gnt !== exp_io || p_gnt !== !exp_io || starved !== exp_io) begin
            failures++;
            $display("FAIL starve_cyc%0d: io_gnt=%b p_gnt=%b starved=%b expected %b %b %b",
                     c, io_gnt, p_gnt, starved, exp_io, !exp_io, exp_io);
         end
         checks++;
         if (p_rvalid !== prev_p || io_rvalid !== prev_io) begin
            failures++;
            $display("FAIL starve_rvalid%0d: p_rvalid=%b io_rvalid=%b expected %b %b",
                     c, p_rvalid, io_rvalid, prev_p, prev_io);
         end
         if (prev_p) begin
            exp_d = exp_p_q.pop_front();
            checks++;
            if (p_rdata !== exp_d) begin
               failures++;
               $display("FAIL starve_pdata%0d: p_rdata=%h expected %h", c, p_rdata, exp_d);
            end
         end
         if (prev_io) begin
            exp_d = exp_io_q.pop_front();
            checks++;
            if (io_rdata !== exp_d) begin
               failures++;
               $display("FAIL starve_iodata%0d: io_rdata=%h expected %h", c, io_rdata, exp_d);
            end
         end
         if (exp_io) exp_io_q.push_back(20'hABCDE);
         else        exp_p_q.push_back(20'h00004);
         prev_p = !exp_io; prev_io = exp_io;
         tick();
      end
      idle_inputs();
      #3;
      exp_d = exp_p_q.pop_front();
      checks++;
      if (p_rvalid !== 1'b1 || p_rdata !== exp_d || io_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL starve_last: p_rvalid=%b p_rdata=%h io_rvalid=%b expected 1 %h 0",
                  p_rvalid, p_rdata, io_rvalid, exp_d);
      end
   endtask

   task automatic test_back_to_back();
      tick();
      p_req = 1; p_we = 0; p_addr = 5'h1E;
      #3;
      checks++;
      if (p_gnt !== 1'b1) begin
         failures++;
         $display("FAIL b2b_gnt0: p_gnt=%b expected 1", p_gnt);
      end
      exp_p_q.push_back(20'h00004);
      tick();
      p_addr = 5'h1F;
      #3;
      exp_d = exp_p_q.pop_front();
      checks++;
      if (p_gnt !== 1'b1 || p_rvalid !== 1'b1 || p_rdata !== exp_d) begin
         failures++;
         $display("FAIL b2b_first: p_gnt=%b rvalid=%b rdata=%h expected 1 1 %h", p_gnt, p_rvalid, p_rdata, exp_d);
      end
      exp_p_q.push_back(20'h00005);
      tick();
      p_req = 0;
      #3;
      exp_d = exp_p_q.pop_front();
      checks++;
      if (p_rvalid !== 1'b1 || p_rdata !== exp_d) begin
         failures++;
         $display("FAIL b2b_second: rvalid=%b rdata=%h expected 1 %h", p_rvalid, p_rdata, exp_d);
      end
      tick();
      #3;
      checks++;
      if (p_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end: rvalid=%b expected 0", p_rvalid);
      end
   endtask

   task automatic test_reset_mid_read();
      logic exp_io;
      tick();
      p_req = 1; p_we = 1; p_addr = 5'h1E; p_wdata = 20'h00004;
      io_req = 1; io_we = 0; io_addr = 5'h05;
      for (int c = 0; c < 3; c++) begin
         #3;
         checks++;
         if (p_gnt !== 1'b1 || io_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre%0d: p_gnt=%b io_gnt=%b expected 1 0", c, p_gnt, io_gnt);
         end
         tick();
      end
      p_req = 0; p_we = 0;
      #1;
      checks++;
      if (io_gnt !== 1'b1) begin
         failures++;
         $display("FAIL rst_io_gnt: io_gnt=%b expected 1", io_gnt);
      end
      Resetn = 0;
      #1;
      checks++;
      if (io_gnt !== 1'b0 || p_gnt !== 1'b0 || mem_wr_en !== 1'b0 || io_rdata !== '0) begin
         failures++;
         $display("FAIL rst_drop: io_gnt=%b p_gnt=%b wr=%b io_rdata=%h expected 0 0 0 0",
                  io_gnt, p_gnt, mem_wr_en, io_rdata);
      end
      tick();
      #3;
      checks++;
      if (io_rvalid !== 1'b0 || io_rdata !== '0 || starved !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_return: io_rvalid=%b io_rdata=%h starved=%b expected 0 0 0",
                  io_rvalid, io_rdata, starved);
      end
      tick();
      Resetn = 1;
      p_req = 1; p_we = 1;
      for (int c = 0; c < 5; c++) begin
         #3;
         exp_io = (c == SM);
         checks++;
         if (io_gnt !== exp_io || p_gnt !== !exp_io || starved !== exp_io) begin
            failures++;
            $display("FAIL rst_cnt_clear%0d: io_gnt=%b p_gnt=%b starved=%b expected %b %b %b",
                     c, io_gnt, p_gnt, starved, exp_io, !exp_io, exp_io);
         end
         if (exp_io) exp_io_q.push_back(20'hABCDE);
         tick();
      end
      idle_inputs();
      #3;
      exp_d = exp_io_q.pop_front();
      checks++;
      if (io_rvalid !== 1'b1 || io_rdata !== exp_d) begin
         failures++;
         $display("FAIL rst_after_read: io_rvalid=%b io_rdata=%h expected 1 %h", io_rvalid, io_rdata, exp_d);
      end
   endtask

   task automatic test_idle();
      for (int c = 0; c < 10; c++) begin
         tick();
         #3;
         checks++;
         if (mem_wr_en !== 1'b0 || mem_addr !== '0 || mem_data !== '0 || p_gnt !== 1'b0 || io_gnt !== 1'b0 ||
             p_rvalid !== 1'b0 || io_rvalid !== 1'b0 || starved !== 1'b0) begin
            failures++;
            $display("FAIL idle%0d: wr=%b addr=%h data=%h pg=%b iog=%b prv=%b iorv=%b st=%b expected all 0",
                     c, mem_wr_en, mem_addr, mem_data, p_gnt, io_gnt, p_rvalid, io_rvalid, starved);
         end
      end
      checks++;
      if (exp_p_q.size() != 0 || exp_io_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: p_left=%0d io_left=%0d expected 0 0", exp_p_q.size(), exp_io_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_pipe_read();
      test_io_write();
      test_starvation();
      test_back_to_back();
      test_reset_mid_read();
      test_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
